// File: rtl/inst_mem_responder.sv
// Direct-mapped, write-through instruction/data cache responder in front of a
// single-outstanding backing store.
//
// state   | meaning
// IDLE    | sample request; hits and illegal requests complete combinationally
// RD_MISS | read miss outstanding at backing store, waiting for mem_ack
// WR_THRU | write-through outstanding at backing store, waiting for mem_ack
// FILL    | present the freshly filled word for one cycle
module inst_mem_responder #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 15 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, FILL} state_t;

    state_t            r_state;
    logic              r_valid [LINES];
    logic [TAG_W-1:0]  r_tag   [LINES];
    logic [15:0]       r_data  [LINES];
    logic [14:0]       r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_fill;
    logic              r_hit;
    logic              r_mem_req;
    logic              r_mem_we;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_cap_idx;
    logic [TAG_W-1:0]      w_cap_tag;
    logic                  w_hit;
    logic                  w_illegal;
    logic                  w_unused;

    assign w_idx     = Addr[INDEX_BITS:1];
    assign w_tag     = Addr[15:INDEX_BITS+1];
    assign w_cap_idx = r_addr[INDEX_BITS-1:0];
    assign w_cap_tag = r_addr[14:INDEX_BITS];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_illegal = (Addr[0] && (Rd || Wr)) || (Rd && Wr);
    assign w_unused  = createdump;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = {r_addr, 1'b0};
    assign mem_wdata = r_wdata;

    // Gated by rst so that illegal inputs held during reset report nothing.
    always_comb begin
        Done     = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        DataOut  = 16'h0000;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    if (w_illegal) begin
                        Done = 1'b1;
                        err  = 1'b1;
                    end else if (Rd && w_hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = r_data[w_idx];
                    end
                end
                FILL: begin
                    Done    = 1'b1;
                    DataOut = r_fill;
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        Done     = 1'b1;
                        CacheHit = r_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Stall = (r_state != IDLE) && !Done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_fill    <= '0;
            r_hit     <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_illegal) begin
                        if (Rd && !w_hit) begin
                            r_addr    <= Addr[15:1];
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b0;
                            r_state   <= RD_MISS;
                        end else if (Wr) begin
                            r_addr    <= Addr[15:1];
                            r_wdata   <= DataIn;
                            r_hit     <= w_hit;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b1;
                            r_state   <= WR_THRU;
                            if (w_hit) begin
                                r_data[w_idx] <= DataIn;
                            end
                        end
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        r_valid[w_cap_idx] <= 1'b1;
                        r_tag[w_cap_idx]   <= w_cap_tag;
                        r_data[w_cap_idx]  <= mem_rdata;
                        r_fill             <= mem_rdata;
                        r_mem_req          <= 1'b0;
                        r_state            <= FILL;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                FILL: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter: INDEX_BITS, 3, cache index width; line count = 2^INDEX_BITS, one 16-bit word per line.
REQ-002 Reset is asynchronous and active-low; the design has one clock; ports are named clk and rst as elsewhere in the codebase.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 Addr  input  16  byte address from requester; word aligned when Addr[0]=0.
REQ-006 DataIn  input  16  write data.
REQ-007 Rd  input  1  read request.
REQ-008 Wr  input  1  write request.
REQ-009 createdump  input  1  accepted; no effect on state or outputs.
REQ-010 DataOut  output  16  read data, valid only when Done=1 for a read.
REQ-011 Done  output  1  request complete this cycle.
REQ-012 Stall  output  1  responder busy; requester holds Addr/Rd/Wr/DataIn stable.
REQ-013 CacheHit  output  1  completion was a hit; valid only with Done=1.
REQ-014 err  output  1  illegal request; valid only with Done=1.
REQ-015 mem_req  output  1  backing-store request, held until accepted.
REQ-016 mem_we  output  1  backing-store write qualifier.
REQ-017 mem_addr  output  16  backing-store word-aligned byte address.
REQ-018 mem_wdata  output  16  backing-store write data.
REQ-019 mem_ack  input  1  backing store accepts or completes the request this cycle.
REQ-020 mem_rdata  input  16  read data, valid when mem_ack=1 and mem_we=0.

Function
REQ-021 Address split: index = Addr[INDEX_BITS:1]; tag = Addr[15:INDEX_BITS+1]; each line holds a valid bit, tag and data.
REQ-022 FSM states: IDLE, RD_MISS, WR_THRU, FILL.
REQ-023 IDLE with Addr[0]=1 and (Rd or Wr), or Rd=Wr=1: Done=1, err=1, CacheHit=0, Stall=0, all combinational; no state change.
REQ-024 IDLE read hit (valid and tag match): Done=1, CacheHit=1, DataOut=line data combinationally in the same cycle; Stall=0; stays IDLE.
REQ-025 IDLE read miss: the responder captures Addr, moves to RD_MISS next edge, and asserts Done=0 in that cycle.
REQ-026 IDLE legal write: the responder captures Addr/DataIn and moves to WR_THRU; a hitting line is updated at that edge; a miss does not allocate.
REQ-027 RD_MISS: mem_req=1, mem_we=0, mem_addr={captured[15:1],1'b0}; on an edge with mem_ack=1 the line is written (valid=1, tag, mem_rdata) and the FSM moves to FILL.
REQ-028 FILL: Done=1, CacheHit=0, DataOut=filled word for exactly one cycle, then IDLE.
REQ-029 WR_THRU: mem_req=1, mem_we=1, mem_wdata=captured data; on an mem_ack edge the FSM goes to IDLE; in that cycle Done=1 and CacheHit equals the hit status captured at acceptance.
REQ-030 Stall=1 exactly while the state is not IDLE and Done=0; Stall=0 in IDLE.
REQ-031 mem_req SHALL be a registered state decode and never asserted in IDLE or FILL; mem_addr/mem_we/mem_wdata stay stable while mem_req=1.
REQ-032 Done is at most one cycle per accepted request; a new request is sampled only in IDLE, so back-to-back hits complete one per cycle.
REQ-033 mem_ack while mem_req=0 is ignored.
REQ-034 Line replacement on a read miss overwrites the indexed line unconditionally (direct-mapped, write-through, no dirty state).

Reset
REQ-035 rst=0 asynchronously forces IDLE and clears all valid bits; Done, Stall, CacheHit, err, mem_req, mem_we = 0, and DataOut, mem_addr, mem_wdata = 0 while in reset.
REQ-036 Reset during RD_MISS/WR_THRU abandons the transaction; mem_req drops immediately; no line is written.
REQ-037 The first read after reset misses for every index.

Verification
REQ-038 After reset, Rd=1, Addr=16'h0010, mem_ack 3 cycles later with mem_rdata=16'hA5A5 -> Stall=1 for 4 cycles, then Done=1, CacheHit=0, DataOut=16'hA5A5 for 1 cycle.
REQ-039 Repeat Rd Addr=16'h0010 -> same-cycle Done=1, CacheHit=1, DataOut=16'hA5A5, mem_req=0.
REQ-040 Rd Addr=16'h0020 (same index, new tag; INDEX_BITS=3), fill 16'h1234; then Rd 16'h0010 -> miss (line evicted).
REQ-041 Rd Addr=16'h0011 -> Done=1, err=1, no mem_req; Rd=Wr=1 Addr=16'h0010 -> err=1.
REQ-042 Wr Addr=16'h0010 DataIn=16'h5A5A on a resident line -> mem_req/mem_we=1 until ack, Done=1, CacheHit=1; the next Rd hits with 16'h5A5A.
REQ-043 rst low mid RD_MISS -> mem_req=0 immediately; after release, Rd on the same address misses.
